// File: rtl/canvas_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// canvas_pkg : shared canvas geometry, state encoding and stream widths
// Rev 1.0
// ============================================================================
package canvas_pkg;

    localparam int CANVAS_DIM    = 28;
    localparam int CANVAS_PIXELS = CANVAS_DIM * CANVAS_DIM;
    localparam int PIX_MAX       = 2048;

    localparam int COORD_W = 5;
    localparam int CELL_W  = 16;
    localparam int PIX_W   = 8;
    localparam int DIGIT_W = 4;
    localparam int TCNT_W  = 8;

    localparam logic [COORD_W-1:0] COORD_LAST = COORD_W'(CANVAS_DIM - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_WAIT_NN = 3'd3,
        ST_SHOW    = 3'd4
    } sched_state_t;

    function automatic logic is_last_cell(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y);
        return (x == COORD_LAST) && (y == COORD_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/canvas_scheduler_if.sv
`default_nettype none
// ============================================================================
// canvas_scheduler_if : pixel stream and classification handshake to NN core
// Rev 1.0
// ============================================================================
interface canvas_scheduler_if;
    import canvas_pkg::*;

    logic               px_valid;
    logic               px_ready;
    logic [PIX_W-1:0]   px_data;
    logic               px_last;
    logic               nn_start;
    logic               nn_done;
    logic [DIGIT_W-1:0] nn_digit;

    modport master (
        output px_valid, px_data, px_last, nn_start,
        input  px_ready, nn_done, nn_digit
    );

    modport slave (
        input  px_valid, px_data, px_last, nn_start,
        output px_ready, nn_done, nn_digit
    );

endinterface
`default_nettype wire

// File: rtl/canvas_scheduler_pixel_quantizer.sv
`default_nettype none
// ============================================================================
// pixel_quantizer : 16-bit canvas cell to 8-bit pixel, saturating at the top
// Rev 1.0
// ============================================================================
module pixel_quantizer
    import canvas_pkg::*;
(
    input  logic [CELL_W-1:0] cell_i,
    output logic [PIX_W-1:0]  pix_o
);

    // At PIX_MAX-1 the shifted value is already full scale, so saturating
    // from there on keeps the transfer curve monotonic.
    localparam logic [CELL_W-1:0] SAT_LEVEL = CELL_W'(PIX_MAX - 1);

    always_comb begin
        pix_o = cell_i[10:3];
        if (cell_i >= SAT_LEVEL) begin
            pix_o = '1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/canvas_scheduler.sv
`default_nettype none
// ============================================================================
// canvas_scheduler : gates drawing, clears the canvas, streams it to the NN
//                    core and holds the recognised digit.   Rev 1.0
// ============================================================================
module canvas_scheduler
    import canvas_pkg::*;
#(
    parameter int NN_TIMEOUT = 255
)
(
    input  logic                frame_clk,
    input  logic                Reset,
    input  logic                draw_btn,
    input  logic                clear_req,
    input  logic                classify_req,
    output logic                Run,
    output logic                canvas_clear,
    output logic [COORD_W-1:0]  rd_x,
    output logic [COORD_W-1:0]  rd_y,
    input  logic [CELL_W-1:0]   rd_data,
    canvas_scheduler_if.master  nn_if,
    output logic [DIGIT_W-1:0]  digit,
    output logic                digit_valid,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(NN_TIMEOUT - 1);

    sched_state_t       state_q,  state_d;
    logic [COORD_W-1:0] x_q,      x_d;
    logic [COORD_W-1:0] y_q,      y_d;
    logic [TCNT_W-1:0]  tcnt_q,   tcnt_d;
    logic [DIGIT_W-1:0] digit_q,  digit_d;
    logic               dvalid_q, dvalid_d;
    logic               terr_q,   terr_d;

    logic               streaming;
    logic               waiting;
    logic               drawable;
    logic               at_last;
    logic               xfer;
    logic [PIX_W-1:0]   quant_pix;

    assign streaming = (state_q == ST_STREAM);
    assign waiting   = (state_q == ST_WAIT_NN);
    assign drawable  = (state_q == ST_IDLE) || (state_q == ST_SHOW);
    assign at_last   = is_last_cell(x_q, y_q);
    assign xfer      = streaming && nn_if.px_ready;

    pixel_quantizer u_quant (
        .cell_i (rd_data),
        .pix_o  (quant_pix)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            tcnt_q   <= '0;
            digit_q  <= '0;
            dvalid_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            tcnt_q   <= tcnt_d;
            digit_q  <= digit_d;
            dvalid_q <= dvalid_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        tcnt_d   = tcnt_q;
        digit_d  = digit_q;
        dvalid_d = dvalid_q;
        terr_d   = terr_q;

        unique case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (clear_req) begin
                    state_d  = ST_CLEAR;
                    dvalid_d = 1'b0;
                    terr_d   = 1'b0;
                end else if (classify_req) begin
                    state_d  = ST_STREAM;
                    x_d      = '0;
                    y_d      = '0;
                    dvalid_d = 1'b0;
                    terr_d   = 1'b0;
                end
            end

            ST_CLEAR: begin
                state_d = ST_IDLE;
            end

            ST_STREAM: begin
                if (xfer) begin
                    if (x_q == COORD_LAST) begin
                        x_d = '0;
                        if (y_q == COORD_LAST) begin
                            y_d     = '0;
                            tcnt_d  = '0;
                            state_d = ST_WAIT_NN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end

            ST_WAIT_NN: begin
                // A verdict in the final counted cycle still beats the timeout.
                if (nn_if.nn_done) begin
                    digit_d  = nn_if.nn_digit;
                    dvalid_d = 1'b1;
                    tcnt_d   = '0;
                    state_d  = ST_SHOW;
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    terr_d   = 1'b1;
                    tcnt_d   = '0;
                    state_d  = ST_IDLE;
                end else begin
                    tcnt_d   = tcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Run          = draw_btn && drawable;
    assign canvas_clear = (state_q == ST_CLEAR);
    assign rd_x         = x_q;
    assign rd_y         = y_q;
    assign busy         = streaming || waiting;

    // Pixel lines read zero outside STREAM so the core never sees stale data.
    assign nn_if.px_valid = streaming;
    assign nn_if.px_data  = streaming ? quant_pix : '0;
    assign nn_if.px_last  = streaming && at_last;
    assign nn_if.nn_start = waiting && (tcnt_q == '0);

    assign digit       = digit_q;
    assign digit_valid = dvalid_q;
    assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_canvas_scheduler.sv
`default_nettype none
// ============================================================================
// tb_canvas_scheduler : directed + randomised checks against a canvas model
// Rev 1.0
// ============================================================================
module tb_canvas_scheduler;
    import canvas_pkg::*;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        draw_btn;
    logic        clear_req;
    logic        classify_req;
    logic        Run;
    logic        canvas_clear;
    logic [4:0]  rd_x;
    logic [4:0]  rd_y;
    logic [15:0] rd_data;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        busy;
    logic        timeout_err;

    canvas_scheduler_if bus ();

    canvas_scheduler #(.NN_TIMEOUT(255)) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .draw_btn     (draw_btn),
        .clear_req    (clear_req),
        .classify_req (classify_req),
        .Run          (Run),
        .canvas_clear (canvas_clear),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_data      (rd_data),
        .nn_if        (bus.master),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 frame_clk = ~frame_clk;

    logic [15:0] canvas [CANVAS_PIXELS];

    always_comb begin
        int idx;
        idx = int'(rd_y) * CANVAS_DIM + int'(rd_x);
        rd_data = (idx < CANVAS_PIXELS) ? canvas[idx] : 16'hDEAD;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int quant(input int v);
        return (v >= 2047) ? 255 : v / 8;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, ".Run"},          Run, 0);
        check({tag, ".canvas_clear"}, canvas_clear, 0);
        check({tag, ".rd_x"},         rd_x, 0);
        check({tag, ".rd_y"},         rd_y, 0);
        check({tag, ".px_valid"},     bus.px_valid, 0);
        check({tag, ".px_data"},      bus.px_data, 0);
        check({tag, ".px_last"},      bus.px_last, 0);
        check({tag, ".nn_start"},     bus.nn_start, 0);
        check({tag, ".digit"},        digit, 0);
        check({tag, ".digit_valid"},  digit_valid, 0);
        check({tag, ".busy"},         busy, 0);
        check({tag, ".timeout_err"},  timeout_err, 0);
    endtask

    // mode 0: ready high, 1: ready toggles, 2: ready random.
    // abort_at >= 0 returns as soon as that pixel is presented.
    task automatic stream(input int mode, input bit noise, input int abort_at, output int cycles);
        int k;
        bit rdy;
        k = 0;
        cycles = 0;
        while (k < CANVAS_PIXELS && cycles < 6000) begin
            @(negedge frame_clk);
            cycles++;
            if (k == abort_at) return;
            check("st.px_valid",     bus.px_valid, 1);
            check("st.busy",         busy, 1);
            check("st.Run",          Run, 0);
            check("st.canvas_clear", canvas_clear, 0);
            check("st.nn_start",     bus.nn_start, 0);
            check("st.digit_valid",  digit_valid, 0);
            check("st.timeout_err",  timeout_err, 0);
            check("st.rd_x",         rd_x, k % CANVAS_DIM);
            check("st.rd_y",         rd_y, k / CANVAS_DIM);
            check("st.px_data",      bus.px_data, quant(int'(canvas[k])));
            check("st.px_last",      bus.px_last, (k == CANVAS_PIXELS - 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2 == 0);
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            if (noise) begin
                clear_req    = $urandom_range(0, 1) == 1;
                classify_req = $urandom_range(0, 1) == 1;
                draw_btn     = $urandom_range(0, 1) == 1;
            end else begin
                classify_req = 1'b0;
            end
            bus.px_ready = rdy;
            if (rdy) k++;
        end
        check("st.transfers", k, CANVAS_PIXELS);
    endtask

    // delay < 0: no verdict, expect the timeout path.
    task automatic wait_nn(input int delay, input logic [3:0] dg);
        int i;
        i = 0;
        while (i < 400) begin
            @(negedge frame_clk);
            if (i == 0) begin
                clear_req    = 1'b0;
                classify_req = 1'b0;
                bus.px_ready = 1'b0;
            end
            if (!busy) break;
            check("wt.nn_start", bus.nn_start, (i == 0));
            check("wt.px_valid", bus.px_valid, 0);
            check("wt.Run",      Run, 0);
            bus.nn_done  = (i == delay);
            bus.nn_digit = (i == delay) ? dg : 4'($urandom);
            i++;
        end
        bus.nn_done = 1'b0;
        if (delay >= 0) begin
            check("wt.cycles",      i, delay + 1);
            check("wt.digit",       digit, dg);
            check("wt.digit_valid", digit_valid, 1);
            check("wt.timeout_err", timeout_err, 0);
        end else begin
            check("to.cycles",      i, 255);
            check("to.timeout_err", timeout_err, 1);
            check("to.digit_valid", digit_valid, 0);
            check("to.busy",        busy, 0);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < CANVAS_PIXELS; i++) begin
            case ($urandom_range(0, 3))
                0:       canvas[i] = 16'($urandom_range(2040, 2056));
                1:       canvas[i] = 16'($urandom);
                default: canvas[i] = 16'($urandom_range(0, 2046));
            endcase
        end
    endtask

    initial begin
        int cyc;
        logic [3:0] dg;

        Reset        = 1'b1;
        draw_btn     = 1'b0;
        clear_req    = 1'b0;
        classify_req = 1'b0;
        bus.px_ready = 1'b0;
        bus.nn_done  = 1'b0;
        bus.nn_digit = 4'd0;
        for (int i = 0; i < CANVAS_PIXELS; i++) canvas[i] = 16'd1000;

        repeat (3) @(negedge frame_clk);
        check_reset_vals("rst");
        Reset = 1'b0;

        // Idle drawing
        @(negedge frame_clk);
        draw_btn = 1'b1;
        #1 check("idle.Run", Run, 1);

        // Canvas of 1000s, ready held high, verdict 7 three cycles after nn_start
        classify_req = 1'b1;
        stream(0, 1'b0, -1, cyc);
        check("A.cycles", cyc, CANVAS_PIXELS);
        wait_nn(3, 4'd7);
        @(negedge frame_clk);
        check("A.show.Run",   Run, 1);
        check("A.show.digit", digit, 7);
        check("A.show.valid", digit_valid, 1);

        // Verdict strobe outside WAIT_NN is ignored
        bus.nn_done  = 1'b1;
        bus.nn_digit = 4'd2;
        @(negedge frame_clk);
        bus.nn_done  = 1'b0;
        @(negedge frame_clk);
        check("B.digit", digit, 7);
        check("B.busy",  busy, 0);

        // Clear beats classify in SHOW
        clear_req    = 1'b1;
        classify_req = 1'b1;
        @(negedge frame_clk);
        clear_req    = 1'b0;
        classify_req = 1'b0;
        check("C.canvas_clear", canvas_clear, 1);
        check("C.busy",         busy, 0);
        check("C.Run",          Run, 0);
        @(negedge frame_clk);
        check("C.clear_once",   canvas_clear, 0);
        check("C.digit_valid",  digit_valid, 0);
        check("C.busy2",        busy, 0);

        // Single saturated cell at (5,3), ready toggling, requests noise, timeout
        for (int i = 0; i < CANVAS_PIXELS; i++) canvas[i] = 16'd0;
        canvas[3 * CANVAS_DIM + 5] = 16'd2048;
        classify_req = 1'b1;
        stream(1, 1'b1, -1, cyc);
        check("D.cycles", cyc, 2 * CANVAS_PIXELS);
        wait_nn(-1, 4'd0);
        draw_btn = 1'b1;
        #1 check("D.idle.Run", Run, 1);

        // Verdict strobe in IDLE is ignored
        @(negedge frame_clk);
        bus.nn_done  = 1'b1;
        bus.nn_digit = 4'd9;
        @(negedge frame_clk);
        bus.nn_done  = 1'b0;
        check("E.digit_valid", digit_valid, 0);
        check("E.timeout_err", timeout_err, 1);

        // Reset in the middle of a stream at pixel 300
        fill_random();
        classify_req = 1'b1;
        stream(2, 1'b0, 300, cyc);
        draw_btn = 1'b0;
        Reset    = 1'b1;
        #1 check_reset_vals("F.rst");
        @(negedge frame_clk);
        check_reset_vals("F.rst2");
        Reset = 1'b0;
        @(negedge frame_clk);
        classify_req = 1'b1;
        stream(2, 1'b0, -1, cyc);
        wait_nn(0, 4'd4);

        // Randomised rounds
        for (int r = 0; r < 3; r++) begin
            fill_random();
            @(negedge frame_clk);
            classify_req = 1'b1;
            stream(2, r[0], -1, cyc);
            dg = 4'($urandom);
            wait_nn(int'($urandom_range(0, 40)), dg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/canvas_scheduler.md
# canvas_scheduler

Sequencer that owns the 28x28 drawing canvas in the MNIST demo. It gates mouse drawing into the canvas editor and issues clear pulses. On a classify request it streams all 784 canvas cells, row-major and quantised to 8 bits, to the neural-network core over a valid/ready handshake. It then waits for the core's verdict and holds the recognised digit for display.

## Interface
- `NN_TIMEOUT`, default 255: frame_clk cycles allowed in WAIT_NN before the block aborts.
- `frame_clk` in, 1: block clock.
- `Reset` in, 1: asynchronous, active-high.
- `draw_btn` in, 1: mouse left button, level.
- `clear_req` in, 1: request to clear the canvas, level, sampled each cycle.
- `classify_req` in, 1: request to classify, level, sampled each cycle.
- `Run` out, 1: draw enable to the canvas editor.
- `canvas_clear` out, 1: one-cycle clear pulse to the canvas editor.
- `rd_x`, `rd_y` out, 5 each: canvas cell read address.
- `rd_data` in, 16: canvas cell value at (`rd_x`, `rd_y`), combinational read.
- `px_valid` out, 1: pixel stream valid.
- `px_ready` in, 1: pixel stream ready.
- `px_data` out, 8: quantised pixel.
- `px_last` out, 1: marks pixel 783.
- `nn_start` out, 1: one-cycle pulse after the last pixel is accepted.
- `nn_done` in, 1: result strobe from the core.
- `nn_digit` in, 4: result value, valid with `nn_done`.
- `digit` out, 4: held result.
- `digit_valid` out, 1: `digit` is meaningful.
- `busy` out, 1: high in STREAM and WAIT_NN.
- `timeout_err` out, 1: sticky flag, cleared by the next classify or clear.

## Operation
- States:
  - IDLE: drawing allowed.
  - CLEAR: one cycle.
  - STREAM
  - WAIT_NN
  - SHOW: result held, drawing allowed.
- Transitions from IDLE or SHOW:
  - `clear_req` takes priority over `classify_req`.
  - `clear_req` -> CLEAR.
  - `classify_req` -> STREAM.
  - While `busy`, both requests are ignored and are not queued.
- CLEAR: `canvas_clear`=1 for exactly one cycle, `digit_valid`<=0, `timeout_err`<=0, then IDLE.
- `Run` = `draw_btn` AND state in {IDLE, SHOW}. `Run` is 0 in CLEAR, STREAM and WAIT_NN, so the canvas is frozen during readout.
- STREAM:
  - Entry resets the counters (x=0, y=0) and clears `timeout_err` and `digit_valid`.
  - `rd_x`=x, `rd_y`=y; `px_valid`=1.
  - `px_data` = 255 if `rd_data` >= 2047, else `rd_data[10:3]`.
  - `px_last`=1 when x=27 and y=27.
  - A transfer occurs when `px_valid` AND `px_ready`. On a transfer, x increments; when x wraps 27->0, y increments.
  - The transfer at (27,27) -> WAIT_NN.
  - While `px_ready`=0, address, `px_data` and `px_last` stay stable.
- WAIT_NN:
  - `nn_start`=1 in the first cycle only.
  - A cycle counter increments every cycle.
  - `nn_done` is honoured in any WAIT_NN cycle, including the first: `digit`<=`nn_digit`, `digit_valid`<=1, -> SHOW.
  - If the counter reaches `NN_TIMEOUT` with no `nn_done`: `timeout_err`<=1, `digit_valid` stays 0, -> IDLE.
- SHOW behaves like IDLE, but `digit` and `digit_valid`=1 are held. Drawing does not clear the result.
- `nn_done` outside WAIT_NN is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `Run`=0, `canvas_clear`=0, `rd_x`=0, `rd_y`=0.
  - `px_valid`=0, `px_data`=0, `px_last`=0.
  - `nn_start`=0.
  - `digit`=0, `digit_valid`=0, `busy`=0, `timeout_err`=0.
- Reset mid-STREAM or mid-WAIT_NN returns the block to IDLE immediately. The partial stream is abandoned and no `px_last` is issued.
- `classify_req` sampled high at edge N puts the block in STREAM from edge N. `px_valid` is high in the cycle after edge N.
- With `px_ready` held high, the stream lasts exactly 784 cycles. `nn_start` is high in cycle 785 after entry.
- Result latency: `digit_valid` rises on the edge after the `nn_done` cycle.
- The counters are 5 bits (x, y) and 8 bits (timeout). No other arithmetic is needed. `rd_data` values above 2048 saturate to 255.

## Structure
- `canvas_pkg` holds:
  - the state enum `sched_state_t`;
  - `CANVAS_DIM`=28, `CANVAS_PIXELS`=784, `PIX_MAX`=2048.
- Sub-module `pixel_quantizer`: a combinational 16->8 saturate-and-shift stage, kept separate so the NN core can reuse it.
- `canvas_scheduler` contains the FSM, the x/y scan counters and the timeout counter.

## Test plan
- Reset asserted mid-STREAM at pixel 300 -> all outputs return to their reset values; state IDLE; the next classify starts at (0,0).
- `classify_req` with `px_ready`=1 and the canvas filled with 1000 -> 784 transfers, each `px_data`=125; `px_last` only on transfer 784; one `nn_start` pulse.
- `px_ready` toggled 0/1 every cycle, one cell at (5,3)=2048 -> 784 transfers over about 1568 cycles; address held during stalls; pixel index 89 = 255, all others 0.
- `nn_done` with `nn_digit`=7 three cycles after `nn_start` -> `digit`=7, `digit_valid`=1; then `draw_btn`=1 gives `Run`=1 with `digit` still 7.
- No `nn_done` -> `timeout_err`=1 after 255 cycles in WAIT_NN; state IDLE; `digit_valid`=0.
- `clear_req` and `classify_req` both high in SHOW -> CLEAR wins; one `canvas_clear` pulse; `digit_valid`=0. Both requests raised during STREAM -> ignored.
